// File: rtl/risc_controller.sv
// Instruction-sequencing controller for the 8-bit RISC CPU: an 8-phase
// instruction cycle with a sticky halt, decoding memory/PC/IR/AC strobes.
module risc_controller #(
  parameter int OPC_W   = 3,
  parameter int PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  output logic [PHASE_W-1:0] phase,
  output logic               sel,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               data_e,
  output logic               halt
);

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [OPC_W-1:0] OPC_HLT = 3'b000;
  localparam logic [OPC_W-1:0] OPC_SKZ = 3'b001;
  localparam logic [OPC_W-1:0] OPC_ADD = 3'b010;
  localparam logic [OPC_W-1:0] OPC_AND = 3'b011;
  localparam logic [OPC_W-1:0] OPC_XOR = 3'b100;
  localparam logic [OPC_W-1:0] OPC_LDA = 3'b101;
  localparam logic [OPC_W-1:0] OPC_STO = 3'b110;
  localparam logic [OPC_W-1:0] OPC_JMP = 3'b111;

  phase_e phase_q;
  logic   halted_q;

  logic is_hlt, is_skz, is_sto, is_jmp, is_aluop, halt_now;

  assign is_hlt   = (opcode == OPC_HLT);
  assign is_skz   = (opcode == OPC_SKZ);
  assign is_sto   = (opcode == OPC_STO);
  assign is_jmp   = (opcode == OPC_JMP);
  assign is_aluop = (opcode == OPC_ADD) || (opcode == OPC_AND) ||
                    (opcode == OPC_XOR) || (opcode == OPC_LDA);

  // A HLT seen in OP_ADDR freezes the phase at OP_ADDR from the next edge on.
  assign halt_now = (phase_q == OP_ADDR) && is_hlt && !halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else if (halt_now) begin
      halted_q <= 1'b1;
    end else if (!halted_q) begin
      phase_q <= phase_e'(phase_q + PHASE_W'(1));
    end
  end

  assign phase = phase_q;

  always_comb begin
    sel          = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    ld_ir        = 1'b0;
    inc_pc       = 1'b0;
    ld_pc        = 1'b0;
    ld_ac        = 1'b0;
    data_e       = 1'b0;
    halt         = halted_q;
    if (!halted_q) begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel         = 1'b1;
          mem_read_en = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel         = 1'b1;
          mem_read_en = 1'b1;
          ld_ir       = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        OP_FETCH: begin
          mem_read_en = is_aluop;
        end
        ALU_OP: begin
          mem_read_en = is_aluop;
          inc_pc      = is_skz && zero;
          ld_pc       = is_jmp;
          data_e      = is_sto;
        end
        STORE: begin
          mem_read_en  = is_aluop;
          ld_ac        = is_aluop;
          ld_pc        = is_jmp;
          data_e       = is_sto;
          mem_write_en = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  // Bus-contention guards on the shared memory data bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_read_en && mem_write_en))
        else $error("read and write strobes both active");
      assert (!(data_e && mem_read_en))
        else $error("accumulator drives bus during memory read");
    end
  end

endmodule
